// File: rtl/freq_meter_if.sv
// Control and result bundle of the frequency meter.
// CNT_W must match the CNT_W of the freq_meter instance it connects to.
interface freq_meter_if #(
    parameter int CNT_W = 26
);
    logic             start;
    logic             continuous;
    logic             sig_in;
    logic [CNT_W-1:0] freq;
    logic             freq_valid;
    logic             busy;
    logic             overflow;

    modport master (
        output start, continuous, sig_in,
        input  freq, freq_valid, busy, overflow
    );

    modport slave (
        input  start, continuous, sig_in,
        output freq, freq_valid, busy, overflow
    );
endinterface

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous square wave over a GATE_CYCLES-clock window.
// Latency: result and freq_valid pulse GATE_CYCLES cycles after busy rises; edges seen 3 clk late.
// No backpressure: freq_valid is a one-cycle pulse, start while busy is dropped.
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    freq_meter_if.slave  bus
);
    localparam int               GW   = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX  = '1;

    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

    state_t           state_q;
    logic             sync1_q, sync2_q, prev_q;
    logic [GW-1:0]    gate_cnt_q;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             ovf_q, ovf_d;
    logic             single_q;
    logic [CNT_W-1:0] freq_q;
    logic             freq_valid_q, busy_q, overflow_q;
    logic             rise;

    assign rise = sync2_q & ~prev_q;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        if (rise) begin
            if (edge_cnt_q == MAX) ovf_d = 1'b1;
            else                   edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            single_q     <= 1'b0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= bus.sig_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            freq_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start || bus.continuous) begin
                        state_q    <= GATE;
                        busy_q     <= 1'b1;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        ovf_q      <= 1'b0;
                        // An explicit start always means exactly one window.
                        single_q   <= bus.start;
                    end
                end
                GATE: begin
                    gate_cnt_q <= gate_cnt_q + GW'(1);
                    edge_cnt_q <= edge_cnt_d;
                    ovf_q      <= ovf_d;
                    if (gate_cnt_q == LAST) begin
                        freq_q       <= edge_cnt_d;
                        overflow_q   <= ovf_d;
                        freq_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.continuous && !single_q) begin
                        state_q    <= GATE;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        ovf_q      <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.freq       = freq_q;
    assign bus.freq_valid = freq_valid_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: GATE_CYCLES=100 with an 8-bit and a 4-bit counter instance.
module tb_freq_meter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic sig_in;
    logic cont = 1'b0;
    logic start8 = 1'b0;
    logic start4 = 1'b0;
    int   period = 6;
    logic hold_lvl = 1'b0;
    bit   sel4 = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    freq_meter_if #(.CNT_W(8)) if8 ();
    freq_meter_if #(.CNT_W(4)) if4 ();

    assign if8.sig_in     = sig_in;
    assign if8.continuous = cont;
    assign if8.start      = start8;
    assign if4.sig_in     = sig_in;
    assign if4.continuous = 1'b0;
    assign if4.start      = start4;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    logic [7:0] f_s;
    logic       v_s, b_s, o_s;
    always_comb begin
        f_s = if8.freq;
        v_s = if8.freq_valid;
        b_s = if8.busy;
        o_s = if8.overflow;
        if (sel4) begin
            f_s = {4'b0, if4.freq};
            v_s = if4.freq_valid;
            b_s = if4.busy;
            o_s = if4.overflow;
        end
    end

    // Square wave of 'period' clocks, or a constant level when period is 0.
    initial begin
        sig_in = 1'b0;
        forever begin
            if (period == 0) begin
                @(posedge clk);
                #2 sig_in = hold_lvl;
            end else begin
                repeat (period / 2) @(posedge clk);
                #2 sig_in = ~sig_in;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Called at the negedge where busy is first visible; returns at the negedge showing freq_valid.
    task automatic wait_result(input string tag, output int busy_cyc,
                               output logic [7:0] f, output logic ovf);
        busy_cyc = 0;
        f        = '0;
        ovf      = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (b_s) busy_cyc++;
            if (v_s) begin
                f   = f_s;
                ovf = o_s;
                return;
            end
            @(negedge clk);
        end
        chk({tag, "_timeout"}, 0, 1);
        busy_cyc = -1;
    endtask

    task automatic one_shot(input bit use4, input string tag, input int lo, input int hi,
                            input int exp_ovf);
        int         bc;
        logic [7:0] f;
        logic       ovf;
        sel4 = use4;
        if (use4) start4 = 1'b1;
        else      start8 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        wait_result(tag, bc, f, ovf);
        chk({tag, "_busy_cycles"}, bc, 101);
        chk({tag, "_freq_in_range"}, (f >= lo && f <= hi), 1);
        chk({tag, "_overflow"}, ovf, exp_ovf);
        @(negedge clk);
        chk({tag, "_busy_after"}, b_s, 0);
        chk({tag, "_valid_one_cycle"}, v_s, 0);
    endtask

    int   vidx[$];
    int   vfrq[$];
    int   lowbusy, dbl, waited;
    logic pv;

    initial begin
        // 1. Reset held: outputs stay zero despite activity.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start8 = i[0];
            start4 = i[0];
            chk("reset_outputs", {if8.freq, if8.freq_valid, if8.busy, if8.overflow,
                                  if4.freq, if4.freq_valid, if4.busy, if4.overflow}, 0);
        end
        start8 = 1'b0;
        start4 = 1'b0;
        rst_n  = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", if8.busy, 0);

        // 2. Single window, period 10.
        period = 10;
        repeat (5) @(negedge clk);
        one_shot(0, "p10", 9, 11, 0);
        repeat (20) @(negedge clk);
        chk("p10_hold", (if8.freq >= 9 && if8.freq <= 11), 1);

        // 5. Constant input gives zero count but still a result pulse.
        period   = 0;
        hold_lvl = 1'b0;
        repeat (5) @(negedge clk);
        one_shot(0, "hold0", 0, 0, 0);
        hold_lvl = 1'b1;
        repeat (5) @(negedge clk);
        one_shot(0, "hold1", 0, 0, 0);

        // 3. Continuous mode, period 4, extra starts ignored.
        sel4   = 1'b0;
        period = 4;
        repeat (5) @(negedge clk);
        cont = 1'b1;
        @(negedge clk);
        lowbusy = 0;
        dbl     = 0;
        pv      = 1'b0;
        for (int i = 0; i < 400 && vidx.size() < 3; i++) begin
            start8 = (i == 40 || i == 150);
            if (!b_s) lowbusy++;
            if (v_s) begin
                if (pv) dbl++;
                vidx.push_back(i);
                vfrq.push_back(f_s);
            end
            pv = v_s;
            @(negedge clk);
        end
        start8 = 1'b0;
        chk("cont_results", vidx.size(), 3);
        if (vidx.size() == 3) begin
            chk("cont_first", vidx[0], 100);
            chk("cont_gap1", vidx[1] - vidx[0], 101);
            chk("cont_gap2", vidx[2] - vidx[1], 101);
            for (int k = 0; k < 3; k++)
                chk("cont_freq_in_range", (vfrq[k] >= 24 && vfrq[k] <= 26), 1);
        end
        chk("cont_busy_gaps", lowbusy, 0);
        chk("cont_double_valid", dbl, 0);
        cont   = 1'b0;
        waited = 0;
        while (if8.busy && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("cont_stops", if8.busy, 0);

        // 6. Reset mid-window: immediate clear, then a full fresh window.
        period = 10;
        repeat (5) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", if8.busy, 0);
        chk("abort_freq", if8.freq, 0);
        chk("abort_valid", if8.freq_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_stays_idle", if8.busy, 0);
        one_shot(0, "after_abort", 9, 11, 0);

        // 4. Narrow counter: saturation, then a clean result.
        period = 4;
        repeat (5) @(negedge clk);
        one_shot(1, "sat", 15, 15, 1);
        period = 20;
        repeat (30) @(negedge clk);
        one_shot(1, "p20", 5, 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
